div_iter_unit: RTL
==================

# div_iter_unit

Parametrised iterative integer divider computing RISC-V DIV/DIVU/REM/REMU and the W variants. It is the next-generation replacement for the single-radix 64-bit divider in the execute stage. Over the previous divider it adds configurable XLEN and digits per cycle, an output valid/ready handshake with result holding, a kill input for pipeline flush, a full-width partial remainder (correct for unsigned divisors ≥ 2^63), and optional leading-zero early-out.

## Interface
- XLEN, 64: datapath width; legal values are 32 and 64.
- BITS_PER_CYCLE, 1: quotient bits retired per cycle; legal values are 1, 2 and 4.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- operand_a  input  XLEN  dividend.
- operand_b  input  XLEN  divisor.
- i_unsigned  input  1  1 = DIVU/REMU, 0 = signed.
- i_32  input  1  1 = W op on bits [31:0]; ignored (treated as 0) when XLEN=32.
- i_valid  input  1  request valid.
- i_ready  output  1  request accepted on an edge where i_valid && i_ready.
- i_kill  input  1  abort any in-flight or completed-but-unconsumed operation.
- o_quo  output  XLEN  quotient.
- o_rem  output  XLEN  remainder.
- o_valid  output  1  result valid; held until consumed.
- o_ready  input  1  consumer accepts the result on an edge where o_valid && o_ready.

## Operation
- The operating width W is 32 when i_32 is 1, otherwise XLEN. The full iteration count is N = W/BITS_PER_CYCLE.
- State machine:
  - IDLE -> BUSY on accept.
  - BUSY -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE on o_ready, or DONE -> BUSY when a new request is accepted on the same edge.
  - Any state -> IDLE on i_kill.
- i_ready = !i_kill && (IDLE || (DONE && o_ready)).
- Accept step:
  - Sign and magnitude are taken from bit W-1 when signed; operands are zero-extended when unsigned.
  - Latch the dividend magnitude, the divisor magnitude, quo_neg = a_sign ^ b_sign && b_mag != 0, rem_neg = a_sign, and W.
- Each BUSY cycle performs BITS_PER_CYCLE chained restoring steps:
  - rem = {rem, next dividend bit}; if rem ≥ b then rem -= b and the quotient bit is 1.
  - The partial remainder is XLEN+1 bits wide.
- Completion, on the last step:
  - Negate the quotient and/or remainder per quo_neg/rem_neg.
  - In W mode, sign-extend both results from bit 31, including the unsigned W ops.
  - Register o_quo/o_rem and set o_valid.
- Divide by zero produces quo = all-ones (sign-extended in W mode) and rem = dividend, with no special path.
- Signed overflow (most-negative / -1) produces quo = dividend and rem = 0, with no special path.
- o_quo/o_rem are stable while o_valid is high and o_ready is low.

## Timing
- Reset values: state IDLE, o_valid 0, o_quo 0, o_rem 0, and therefore i_ready 1 in the cycle after reset.
- Reset mid-operation discards all state.
- Latency: o_valid is first high N edges after the accepting edge (BITS_PER_CYCLE=1, XLEN=64 gives 64 edges; W op gives 32 edges).
- Throughput: a back-to-back accept is allowed in DONE with o_ready high. The new result follows N edges later, with no bubble cycle added.
- i_kill:
  - Takes effect at the next edge: state becomes IDLE and o_valid becomes 0.
  - A result being consumed on the same edge still counts as consumed.
  - i_kill && i_valid in the same cycle causes no accept.
- i_valid is ignored while i_ready is low; the requester must hold the request.

## Configuration
- Macro: MUNTJAC_DIV_EARLY_OUT_EN.
- Defined:
  - At accept, count the leading zeros z of the W-bit dividend magnitude.
  - Pre-shift the dividend by floor(z/BITS_PER_CYCLE)*BITS_PER_CYCLE.
  - Run max(1, ceil((W-z)/BITS_PER_CYCLE)) iterations.
  - If b_mag == 0, early-out is disabled and all N iterations run.
- Not defined: always N iterations, so latency is data-independent.
- Results are identical in both builds; only latency differs.

## Test plan
- Signed 64-bit, fixed latency, BITS_PER_CYCLE=1: a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> o_quo=0xFFFF_FFFF_FFFF_FFFD, o_rem=0xFFFF_FFFF_FFFF_FFFF, with o_valid exactly 64 edges after accept.
- Unsigned divide by zero: a=0x1234, b=0, i_unsigned=1 -> o_quo=0xFFFF_FFFF_FFFF_FFFF, o_rem=0x1234.
- Overflow and large-divisor cases:
  - Signed a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> o_quo=0x8000_0000_0000_0000, o_rem=0.
  - Unsigned a=0xFFFF_FFFF_FFFF_FFFF, b=0x8000_0000_0000_0001 -> o_quo=1, o_rem=0x7FFF_FFFF_FFFF_FFFE.
- DIVUW: a=0xFFFF_FFFF_8000_0000, b=3, i_32=1, i_unsigned=1 -> o_quo=0x2AAA_AAAA, o_rem=2, with latency 32.
- Handshake:
  - Hold o_ready=0 for 10 cycles after o_valid -> outputs stable throughout.
  - Then assert o_ready with i_valid in the same cycle -> accepted, and the next result arrives N edges later.
  - Assert i_kill on BUSY cycle 5 -> o_valid never rises, and i_ready is 1 the following cycle.
- With MUNTJAC_DIV_EARLY_OUT_EN, BITS_PER_CYCLE=1: a=5, b=1 -> o_quo=5, o_rem=0, with o_valid 3 edges after accept. a=0, b=7 -> 1 edge.

Source files
------------

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative restoring integer divider for DIV/DIVU/REM/REMU
// and their W variants.
//
// Parameters:
//   XLEN           - datapath width (32 or 64)
//   BITS_PER_CYCLE - quotient bits retired per BUSY cycle (1, 2 or 4)
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   operand_a / operand_b    - dividend / divisor
//   i_unsigned, i_32         - unsigned op, W op (bits [31:0]; only when XLEN=64)
//   i_valid / i_ready        - request handshake
//   i_kill                   - flush any in-flight or unconsumed result
//   o_quo / o_rem            - quotient / remainder, held while o_valid && !o_ready
//   o_valid / o_ready        - result handshake
// Build option:
//   MUNTJAC_DIV_EARLY_OUT_EN - skip leading-zero dividend digits at accept,
//                              making latency data-dependent. Results unchanged.
module div_iter_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            i_unsigned,
  input  logic            i_32,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            i_kill,
  output logic [XLEN-1:0] o_quo,
  output logic [XLEN-1:0] o_rem,
  output logic            o_valid,
  input  logic            o_ready
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;

  // Dividend bits still to be consumed sit MSB-aligned in dvd_q.
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic [CW-1:0]   cnt_q;
  logic            quo_neg_q, rem_neg_q, w32_q;
  logic            accept, last;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v, input logic en);
    sext32 = v;
    if (en) for (int i = 32; i < XLEN; i++) sext32[i] = v[31];
  endfunction

  // ---------------- control ----------------
  assign last    = (state == BUSY) && (cnt_q == '0);
  assign o_valid = (state == DONE);

  always_comb begin
    state_n = state;
    i_ready = !i_kill && ((state == IDLE) || ((state == DONE) && o_ready));
    accept  = i_valid && i_ready;
    if (i_kill) state_n = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) state_n = BUSY;
        BUSY:    if (cnt_q == '0) state_n = DONE;
        DONE:    if (accept) state_n = BUSY;
                 else if (o_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // ---------------- accept-side operand prep ----------------
  logic            w32, a_sign, b_sign;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_top;
  logic [CW-1:0]   wbits, shamt, iters;

  always_comb begin
    w32   = (XLEN == 64) && i_32;
    wbits = w32 ? CW'(32) : CW'(XLEN);
    a_ext = operand_a;
    b_ext = operand_b;
    // Widen the W-mode operands so that bit XLEN-1 carries the operand sign.
    if (w32) begin
      for (int i = 32; i < XLEN; i++) begin
        a_ext[i] = !i_unsigned && operand_a[31];
        b_ext[i] = !i_unsigned && operand_b[31];
      end
    end
    a_sign = !i_unsigned && a_ext[XLEN-1];
    b_sign = !i_unsigned && b_ext[XLEN-1];
    a_mag  = a_sign ? -a_ext : a_ext;
    b_mag  = b_sign ? -b_ext : b_ext;
    // MSB-align the W-bit dividend magnitude.
    a_top  = w32 ? (a_mag << (XLEN - 32)) : a_mag;
  end

`ifdef MUNTJAC_DIV_EARLY_OUT_EN
  logic [CW-1:0] lz;
  always_comb begin
    lz = wbits;  // all-zero dividend
    for (int i = 0; i < XLEN; i++) if (a_top[i]) lz = CW'(XLEN - 1 - i);
    // A zero divisor must walk every bit to build the all-ones quotient.
    if (b_mag == '0) lz = '0;
    shamt = (lz / CW'(BITS_PER_CYCLE)) * CW'(BITS_PER_CYCLE);
    iters = (wbits - shamt) / CW'(BITS_PER_CYCLE);
    if (iters == '0) iters = CW'(1);
  end
`else
  always_comb begin
    shamt = '0;
    iters = wbits / CW'(BITS_PER_CYCLE);
  end
`endif

  // ---------------- chained restoring steps ----------------
  logic [XLEN-1:0] s_dvd, s_rem, s_quo, q_mag, r_mag, q_fin, r_fin;
  logic [XLEN:0]   t;

  always_comb begin
    s_dvd = dvd_q;
    s_rem = rem_q;
    s_quo = quo_q;
    t     = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      // XLEN+1 bits so divisors >= 2^(XLEN-1) compare correctly.
      t     = {s_rem, s_dvd[XLEN-1]};
      s_dvd = s_dvd << 1;
      if (t >= {1'b0, dvs_q}) begin
        t     = t - {1'b0, dvs_q};
        s_quo = {s_quo[XLEN-2:0], 1'b1};
      end else begin
        s_quo = {s_quo[XLEN-2:0], 1'b0};
      end
      s_rem = t[XLEN-1:0];
    end
    q_mag = quo_neg_q ? -s_quo : s_quo;
    r_mag = rem_neg_q ? -s_rem : s_rem;
    q_fin = sext32(q_mag, w32_q);
    r_fin = sext32(r_mag, w32_q);
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      w32_q     <= 1'b0;
      o_quo     <= '0;
      o_rem     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        dvd_q     <= a_top << shamt;
        dvs_q     <= b_mag;
        rem_q     <= '0;
        quo_q     <= '0;
        cnt_q     <= iters - CW'(1);
        quo_neg_q <= (a_sign ^ b_sign) && (b_mag != '0);
        rem_neg_q <= a_sign;
        w32_q     <= w32;
      end else if (state == BUSY) begin
        dvd_q <= s_dvd;
        rem_q <= s_rem;
        quo_q <= s_quo;
        cnt_q <= cnt_q - CW'(1);
        if (last && !i_kill) begin
          o_quo <= q_fin;
          o_rem <= r_fin;
        end
      end
    end
  end

endmodule
